// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: in-order pipeline hazard unit (stall, flush, forwarding select, event counters)
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   if_id_*_i           source registers of the instruction in ID and whether each is read
//   id_ex_*_i           ID/EX stage source/destination registers and write/load flags
//   ex_mem_*_i          EX/MEM destination register and write flag
//   mem_wb_*_i          MEM/WB destination register and write flag
//   ex_redirect_i       taken branch / jalr resolved in EX this cycle
//   pc_write_o          PC may advance
//   if_id_write_o       IF/ID may load
//   if_id_flush_o       IF/ID is squashed
//   id_ex_bubble_o      ID/EX control fields are zeroed at the next edge
//   fwd_a_o, fwd_b_o    operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   state_o             RUN=00, STALL=01, REDIRECT=10
//   stall_cnt_o         saturating count of stall cycles
//   flush_cnt_o         saturating count of redirect flushes
//
// Build option HAZARD_FORWARDING_EN: when defined, forwarding is active and only a
// load-use stalls; when undefined, forwarding selects stay 00 and any RAW match
// against ID/EX, EX/MEM or MEM/WB stalls until the writer has drained.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  if_id_rs1_i,
  input  logic [4:0]  if_id_rs2_i,
  input  logic        if_id_use_rs1_i,
  input  logic        if_id_use_rs2_i,
  input  logic [4:0]  id_ex_rs1_i,
  input  logic [4:0]  id_ex_rs2_i,
  input  logic [4:0]  id_ex_rd_i,
  input  logic        id_ex_reg_write_i,
  input  logic        id_ex_mem_read_i,
  input  logic [4:0]  ex_mem_rd_i,
  input  logic        ex_mem_reg_write_i,
  input  logic [4:0]  mem_wb_rd_i,
  input  logic        mem_wb_reg_write_i,
  input  logic        ex_redirect_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, REDIRECT = 2'b10} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_hazard, w_stall_evt, w_flush_evt;
  logic [1:0]  w_fwd_a, w_fwd_b;
  logic        w_unused;

  // x0 is hard-wired zero, so a destination of 0 never matches anything
  function automatic logic f_hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we & (rd != 5'd0) & (rs == rd);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  assign w_hazard = (if_id_use_rs1_i & f_hit(if_id_rs1_i, id_ex_rd_i, id_ex_mem_read_i)) |
                    (if_id_use_rs2_i & f_hit(if_id_rs2_i, id_ex_rd_i, id_ex_mem_read_i));
  // EX/MEM holds the younger result, so it wins over MEM/WB
  assign w_fwd_a = f_hit(id_ex_rs1_i, ex_mem_rd_i, ex_mem_reg_write_i) ? 2'b10 :
                   f_hit(id_ex_rs1_i, mem_wb_rd_i, mem_wb_reg_write_i) ? 2'b01 : 2'b00;
  assign w_fwd_b = f_hit(id_ex_rs2_i, ex_mem_rd_i, ex_mem_reg_write_i) ? 2'b10 :
                   f_hit(id_ex_rs2_i, mem_wb_rd_i, mem_wb_reg_write_i) ? 2'b01 : 2'b00;
  assign w_unused = id_ex_reg_write_i;
`else
  logic w_raw_rs1, w_raw_rs2;
  // without bypass paths every in-flight writer must drain before ID may read
  assign w_raw_rs1 = if_id_use_rs1_i & (f_hit(if_id_rs1_i, id_ex_rd_i, id_ex_reg_write_i) |
                                        f_hit(if_id_rs1_i, ex_mem_rd_i, ex_mem_reg_write_i) |
                                        f_hit(if_id_rs1_i, mem_wb_rd_i, mem_wb_reg_write_i));
  assign w_raw_rs2 = if_id_use_rs2_i & (f_hit(if_id_rs2_i, id_ex_rd_i, id_ex_reg_write_i) |
                                        f_hit(if_id_rs2_i, ex_mem_rd_i, ex_mem_reg_write_i) |
                                        f_hit(if_id_rs2_i, mem_wb_rd_i, mem_wb_reg_write_i));
  assign w_hazard = w_raw_rs1 | w_raw_rs2;
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
  assign w_unused = ^{id_ex_rs1_i, id_ex_rs2_i, id_ex_mem_read_i};
`endif

  // REDIRECT masks both the redirect input (EX holds a bubble) and hazard detection
  always_comb begin
    w_next         = RUN;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    w_stall_evt    = 1'b0;
    w_flush_evt    = 1'b0;
    if (!reset) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (r_state != REDIRECT) begin
      if (ex_redirect_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        w_next         = REDIRECT;
        w_flush_evt    = 1'b1;
      end else if (w_hazard) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        w_next         = STALL;
        w_stall_evt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall_evt && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign fwd_a_o     = reset ? w_fwd_a : 2'b00;
  assign fwd_b_o     = reset ? w_fwd_b : 2'b00;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the pipeline hazard controller
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  if_id_rs1_i, if_id_rs2_i, id_ex_rs1_i, id_ex_rs2_i, id_ex_rd_i, ex_mem_rd_i, mem_wb_rd_i;
  logic        if_id_use_rs1_i, if_id_use_rs2_i, id_ex_reg_write_i, id_ex_mem_read_i;
  logic        ex_mem_reg_write_i, mem_wb_reg_write_i, ex_redirect_i;
  logic        pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
  logic [1:0]  fwd_a_o, fwd_b_o, state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;
  int          checks = 0, passed = 0;
  logic [1:0]  m_state;
  logic [15:0] m_stall, m_flush;
  logic [41:0] sb[$];
  logic [41:0] obs, e;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .if_id_rs1_i(if_id_rs1_i), .if_id_rs2_i(if_id_rs2_i),
    .if_id_use_rs1_i(if_id_use_rs1_i), .if_id_use_rs2_i(if_id_use_rs2_i),
    .id_ex_rs1_i(id_ex_rs1_i), .id_ex_rs2_i(id_ex_rs2_i), .id_ex_rd_i(id_ex_rd_i),
    .id_ex_reg_write_i(id_ex_reg_write_i), .id_ex_mem_read_i(id_ex_mem_read_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_reg_write_i(ex_mem_reg_write_i),
    .mem_wb_rd_i(mem_wb_rd_i), .mem_wb_reg_write_i(mem_wb_reg_write_i),
    .ex_redirect_i(ex_redirect_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, stall_cnt_o, flush_cnt_o, pc_write_o, if_id_write_o, if_id_flush_o,
                id_ex_bubble_o, fwd_a_o, fwd_b_o};

  function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && rs == rd;
  endfunction

  function automatic logic m_hazard();
    logic a;
`ifdef HAZARD_FORWARDING_EN
    a = (if_id_use_rs1_i && hit(if_id_rs1_i, id_ex_rd_i, id_ex_mem_read_i)) ||
        (if_id_use_rs2_i && hit(if_id_rs2_i, id_ex_rd_i, id_ex_mem_read_i));
`else
    a = (if_id_use_rs1_i && (hit(if_id_rs1_i, id_ex_rd_i, id_ex_reg_write_i) ||
                             hit(if_id_rs1_i, ex_mem_rd_i, ex_mem_reg_write_i) ||
                             hit(if_id_rs1_i, mem_wb_rd_i, mem_wb_reg_write_i))) ||
        (if_id_use_rs2_i && (hit(if_id_rs2_i, id_ex_rd_i, id_ex_reg_write_i) ||
                             hit(if_id_rs2_i, ex_mem_rd_i, ex_mem_reg_write_i) ||
                             hit(if_id_rs2_i, mem_wb_rd_i, mem_wb_reg_write_i)));
`endif
    return a;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    logic [1:0] f;
    f = 2'b00;
`ifdef HAZARD_FORWARDING_EN
    if (hit(rs, ex_mem_rd_i, ex_mem_reg_write_i)) f = 2'b10;
    else if (hit(rs, mem_wb_rd_i, mem_wb_reg_write_i)) f = 2'b01;
`endif
    return reset ? f : 2'b00;
  endfunction

  // expected outputs for the current cycle are queued, then the model steps across the edge
  task automatic apply();
    logic pw, iw, fl, bb, st, fc;
    logic [1:0] ns;
    pw = 1; iw = 1; fl = 0; bb = 0; st = 0; fc = 0; ns = 2'b00;
    if (!reset) begin
      pw = 0; iw = 0; fl = 1; bb = 1;
      m_state = 2'b00; m_stall = 16'd0; m_flush = 16'd0;
    end else if (m_state != 2'b10) begin
      if (ex_redirect_i) begin fl = 1; bb = 1; ns = 2'b10; fc = 1; end
      else if (m_hazard()) begin pw = 0; iw = 0; bb = 1; ns = 2'b01; st = 1; end
    end
    sb.push_back({m_state, m_stall, m_flush, pw, iw, fl, bb, m_fwd(id_ex_rs1_i), m_fwd(id_ex_rs2_i)});
    if (reset) begin
      m_state = ns;
      if (st && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (fc && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  task automatic tick();
    apply();
    #1;
    e = sb.pop_front();
  endtask

  task automatic idle();
    if_id_rs1_i = 0; if_id_rs2_i = 0; if_id_use_rs1_i = 0; if_id_use_rs2_i = 0;
    id_ex_rs1_i = 0; id_ex_rs2_i = 0; id_ex_rd_i = 0; id_ex_reg_write_i = 0; id_ex_mem_read_i = 0;
    ex_mem_rd_i = 0; ex_mem_reg_write_i = 0; mem_wb_rd_i = 0; mem_wb_reg_write_i = 0;
    ex_redirect_i = 0;
  endtask

  task automatic set_pipe(input logic [4:0] ie_rd, input logic ie_rw, input logic ie_mr,
                          input logic [4:0] em_rd, input logic em_rw,
                          input logic [4:0] mw_rd, input logic mw_rw);
    id_ex_rd_i = ie_rd; id_ex_reg_write_i = ie_rw; id_ex_mem_read_i = ie_mr;
    ex_mem_rd_i = em_rd; ex_mem_reg_write_i = em_rw;
    mem_wb_rd_i = mw_rd; mem_wb_reg_write_i = mw_rw;
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 2);
    return r == 0 ? 5'd0 : r == 1 ? 5'd3 : 5'd7;
  endfunction

  task automatic test_reset();
    idle();
    @(negedge clk);
    tick(); checks++;
    if (obs !== e) $display("FAIL reset_model: got %h expected %h", obs, e); else passed++;
    checks++;
    if ({pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o} !== 4'b0011 || state_o !== 2'b00 ||
        stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0 || fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00)
      $display("FAIL reset_values: got %h expected state/counters 0, strobes 0011, fwd 00", obs);
    else passed++;
    @(negedge clk);
    id_ex_rs1_i = 7; id_ex_rs2_i = 3; set_pipe(5'd3, 1, 1, 5'd7, 1, 5'd3, 1);
    if_id_rs1_i = 3; if_id_use_rs1_i = 1; ex_redirect_i = 1;
    tick(); checks++;
    if (obs !== e) $display("FAIL reset_held_inputs: got %h expected %h", obs, e); else passed++;
    @(negedge clk);
    reset = 1; idle();
    tick(); checks++;
    if (obs !== e || state_o !== 2'b00 || pc_write_o !== 1'b1)
      $display("FAIL reset_release: got %h expected %h", obs, e);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    logic [15:0] base;
    base = m_stall;
    idle(); if_id_rs1_i = 5; if_id_use_rs1_i = 1;
    for (int k = 0; k < 4; k++) begin
      set_pipe(k == 0 ? 5'd5 : 5'd0, k == 0, k == 0, k == 1 ? 5'd5 : 5'd0, k == 1, k == 2 ? 5'd5 : 5'd0, k == 2);
      tick(); checks++;
      if (obs !== e) $display("FAIL load_use c%0d: got %h expected %h", k, obs, e); else passed++;
      if (k == 0) begin
        checks++;
        if (pc_write_o !== 1'b0 || id_ex_bubble_o !== 1'b1 || if_id_flush_o !== 1'b0)
          $display("FAIL load_use_strobes: got pc=%b bubble=%b flush=%b expected 0 1 0", pc_write_o, id_ex_bubble_o, if_id_flush_o);
        else passed++;
      end
      if (k == 1) begin
        checks++;
        if (state_o !== 2'b01 || stall_cnt_o !== base + 16'd1)
          $display("FAIL load_use_stall: got state=%b cnt=%0d expected 01 %0d", state_o, stall_cnt_o, base + 16'd1);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_hazard();
    logic [15:0] sbase, fbase;
    sbase = m_stall; fbase = m_flush;
    idle(); if_id_rs1_i = 9; if_id_use_rs1_i = 1; set_pipe(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    ex_redirect_i = 1;
    tick(); checks++;
    if (obs !== e || if_id_flush_o !== 1'b1 || id_ex_bubble_o !== 1'b1 || pc_write_o !== 1'b1)
      $display("FAIL redirect_hazard: got %h expected %h", obs, e);
    else passed++;
    @(negedge clk);
    tick(); checks++;
    if (state_o !== 2'b10 || stall_cnt_o !== sbase || flush_cnt_o !== fbase + 16'd1)
      $display("FAIL redirect_counts: got state=%b stall=%0d flush=%0d expected 10 %0d %0d",
               state_o, stall_cnt_o, flush_cnt_o, sbase, fbase + 16'd1);
    else passed++;
    checks++;
    if (obs !== e) $display("FAIL redirect_masked: got %h expected %h", obs, e); else passed++;
    @(negedge clk);
    idle();
    tick(); checks++;
    if (obs !== e || state_o !== 2'b00) $display("FAIL redirect_return: got %h expected %h", obs, e); else passed++;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    logic [1:0] ea, eb;
`ifdef HAZARD_FORWARDING_EN
    ea = 2'b10; eb = 2'b01;
`else
    ea = 2'b00; eb = 2'b00;
`endif
    idle(); id_ex_rs1_i = 7; set_pipe(5'd0, 0, 0, 5'd7, 1, 5'd7, 1);
    tick(); checks++;
    if (fwd_a_o !== ea || obs !== e) $display("FAIL fwd_exmem: got fwd_a=%b expected %b", fwd_a_o, ea); else passed++;
    @(negedge clk);
    ex_mem_rd_i = 0;
    tick(); checks++;
    if (fwd_a_o !== eb || obs !== e) $display("FAIL fwd_memwb: got fwd_a=%b expected %b", fwd_a_o, eb); else passed++;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if_id_rs1_i = pick(); if_id_rs2_i = pick(); id_ex_rs1_i = pick(); id_ex_rs2_i = pick();
      if_id_use_rs1_i = 1'($urandom_range(0, 1)); if_id_use_rs2_i = 1'($urandom_range(0, 1));
      set_pipe(pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)),
               pick(), 1'($urandom_range(0, 1)));
      ex_redirect_i = ($urandom_range(0, 4) == 0);
      tick(); checks++;
      if (obs !== e) $display("FAIL random c%0d: got %h expected %h", k, obs, e); else passed++;
      @(negedge clk);
    end
    idle();
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
  endtask

  task automatic test_x0();
    idle(); if_id_rs1_i = 0; if_id_use_rs1_i = 1; set_pipe(5'd0, 1, 1, 5'd0, 1, 5'd0, 1);
    tick(); checks++;
    if (pc_write_o !== 1'b1 || id_ex_bubble_o !== 1'b0 || obs !== e)
      $display("FAIL x0_no_stall: got %h expected %h", obs, e);
    else passed++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_state();
    for (int k = 0; k < 2; k++) begin
      idle(); if_id_rs2_i = 4; if_id_use_rs2_i = 1; set_pipe(5'd4, 1, 1, 5'd0, 0, 5'd0, 0);
      ex_redirect_i = (k == 1);
      tick();
      @(negedge clk);
      #2 reset = 0;
      tick(); checks++;
      if (obs !== e || id_ex_bubble_o !== 1'b1 || if_id_flush_o !== 1'b1 || state_o !== 2'b00 ||
          stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0)
        $display("FAIL reset_mid_%0d: got %h expected %h", k, obs, e);
      else passed++;
      @(negedge clk);
      reset = 1; idle();
      tick(); checks++;
      if (obs !== e || state_o !== 2'b00) $display("FAIL reset_resume_%0d: got %h expected %h", k, obs, e); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_raw_chain();
    logic [15:0] base;
    logic        fz;
    base = m_stall; fz = 1;
    idle(); if_id_rs1_i = 3; if_id_use_rs1_i = 1;
    for (int k = 0; k < 4; k++) begin
      set_pipe(k == 0 ? 5'd3 : 5'd0, k == 0, 0, k == 1 ? 5'd3 : 5'd0, k == 1, k == 2 ? 5'd3 : 5'd0, k == 2);
      tick(); checks++;
      if (obs !== e) $display("FAIL raw_chain c%0d: got %h expected %h", k, obs, e); else passed++;
      if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) fz = 0;
      @(negedge clk);
    end
    idle();
    tick(); checks++;
`ifdef HAZARD_FORWARDING_EN
    if (stall_cnt_o !== base) $display("FAIL raw_chain_total: got %0d expected %0d", stall_cnt_o, base); else passed++;
`else
    if (stall_cnt_o !== base + 16'd3 || !fz)
      $display("FAIL raw_chain_total: got %0d fwd_zero=%b expected %0d 1", stall_cnt_o, fz, base + 16'd3);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] fbase;
    fbase = m_flush;
    idle(); ex_redirect_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); checks++;
      if (obs !== e) $display("FAIL b2b_redirect c%0d: got %h expected %h", k, obs, e); else passed++;
      @(negedge clk);
    end
    idle();
    tick(); checks++;
    if (flush_cnt_o !== fbase + 16'd2 || state_o !== 2'b10)
      $display("FAIL b2b_flush_count: got %0d state=%b expected %0d 10", flush_cnt_o, state_o, fbase + 16'd2);
    else passed++;
    @(negedge clk);
    tick();
    @(negedge clk);
  endtask

  task automatic test_saturation();
    idle(); if_id_rs1_i = 6; if_id_use_rs1_i = 1; set_pipe(5'd6, 1, 1, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 70000 && m_stall != 16'hFFFF; i++) begin
      apply();
      e = sb.pop_front();
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); checks++;
      if (obs !== e || stall_cnt_o !== 16'hFFFF)
        $display("FAIL stall_saturate c%0d: got cnt=%h obs=%h expected FFFF %h", k, stall_cnt_o, obs, e);
      else passed++;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    m_state = 2'b00; m_stall = 16'd0; m_flush = 16'd0;
    test_reset();
    test_load_use();
    test_redirect_hazard();
    test_forwarding();
    test_x0();
    test_reset_mid_state();
    test_raw_chain();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-002 SHALL have inputs if_id_rs1_i, if_id_rs2_i  5 each  source regs of the instruction in ID; if_id_use_rs1_i, if_id_use_rs2_i  1 each  source actually read.
REQ-003 SHALL have inputs id_ex_rs1_i, id_ex_rs2_i, id_ex_rd_i  5 each; id_ex_reg_write_i, id_ex_mem_read_i  1 each.
REQ-004 SHALL have inputs ex_mem_rd_i  5, ex_mem_reg_write_i  1, mem_wb_rd_i  5, mem_wb_reg_write_i  1.
REQ-005 SHALL have input ex_redirect_i  1  taken branch or jalr resolved in EX this cycle.
REQ-006 SHALL have outputs pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o  1 each; when id_ex_bubble_o=1, all ID/EX control fields are zeroed at the next edge.
REQ-007 SHALL have outputs fwd_a_o, fwd_b_o  2 each: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-008 SHALL have outputs state_o  2, stall_cnt_o  16, flush_cnt_o  16.

Function
REQ-009 Register x0 SHALL never match: rd=0 produces no hazard and no forwarding.
REQ-010 The load-use hazard SHALL be id_ex_mem_read_i & id_ex_rd_i!=0 & ((use_rs1 & rs1==id_ex_rd) | (use_rs2 & rs2==id_ex_rd)).
REQ-011 The FSM SHALL have states RUN=00, STALL=01, REDIRECT=10, registered on the clk rising edge; state_o SHALL equal the current state.
REQ-012 In RUN or STALL, if ex_redirect_i=1: pc_write_o=1, if_id_write_o=1, if_id_flush_o=1, id_ex_bubble_o=1, next state REDIRECT, and flush_cnt_o increments.
REQ-013 A redirect SHALL take priority over any hazard in the same cycle; no stall is raised that cycle.
REQ-014 In RUN or STALL with no redirect and a hazard present: pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, id_ex_bubble_o=1, next state STALL, and stall_cnt_o increments.
REQ-015 With no redirect and no hazard: pc_write_o=1, if_id_write_o=1, flush=0, bubble=0, next state RUN.
REQ-016 REDIRECT SHALL last exactly one cycle and mask hazard detection.
  - ex_redirect_i is ignored in REDIRECT: EX holds a bubble, so the input is invalid.
  - Outputs in REDIRECT: pc_write_o=1, if_id_write_o=1, flush=0, bubble=0.
  - Next state is RUN.
REQ-017 Hazard and strobe outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-018 stall_cnt_o and flush_cnt_o SHALL saturate at 16'hFFFF with no wrap-around.
REQ-019 The fwd_a_o/fwd_b_o select for id_ex_rs1_i/id_ex_rs2_i SHALL be:
  - 10 if ex_mem_reg_write_i & ex_mem_rd_i!=0 & ex_mem_rd_i==rs;
  - otherwise 01 if mem_wb_reg_write_i & mem_wb_rd_i!=0 & mem_wb_rd_i==rs;
  - otherwise 00.
  EX/MEM SHALL have priority over MEM/WB.

Reset
REQ-020 While reset=0, state SHALL be RUN, stall_cnt_o=0, flush_cnt_o=0, pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, fwd_a_o=00, fwd_b_o=00.
REQ-021 Reset asserted mid-STALL or mid-REDIRECT SHALL abort immediately to the REQ-020 values.
REQ-022 On the first rising edge after reset rises, the block SHALL evaluate from RUN.

Configuration
REQ-023 Macro HAZARD_FORWARDING_EN defined: REQ-019 forwarding is active, and only REQ-010 load-use raises a hazard.
REQ-024 Macro HAZARD_FORWARDING_EN undefined:
  - fwd_a_o and fwd_b_o SHALL be constant 00.
  - A hazard SHALL be raised for any used rs matching a nonzero rd with reg_write set in ID/EX, EX/MEM or MEM/WB.
  - The resulting stall SHALL repeat each cycle until no match remains, up to 3 cycles.

Verification
REQ-025 Load-use: lw x5 in ID/EX, ID reads x5 (use_rs1=1) -> one cycle with pc_write_o=0, bubble=1, state STALL, stall_cnt_o=1, then RUN.
REQ-026 Redirect and hazard in the same cycle: ex_redirect_i=1 with load-use active -> flush=1, bubble=1, pc_write_o=1, state REDIRECT, stall_cnt_o unchanged, flush_cnt_o+1.
REQ-027 Forwarding: ex_mem_rd=x7 and mem_wb_rd=x7 (both reg_write=1), id_ex_rs1=x7 -> fwd_a_o=10; ex_mem_rd=x0 instead -> fwd_a_o=01.
REQ-028 x0: id_ex_mem_read=1, id_ex_rd=0, rs1=0 -> no stall, pc_write_o=1.
REQ-029 Reset pulled low in STALL -> immediately bubble=1, flush=1, counters 0; after release, state RUN.
REQ-030 Without HAZARD_FORWARDING_EN: add x3 followed directly by a use of x3 -> 3 stall cycles, stall_cnt_o=3, fwd outputs 00 throughout.
